// File: rtl/toast_mem_stage.sv
// MEM pipeline stage: steers ALU results to writeback or to a single-outstanding
// req/ack data-memory port, with alignment checks, load extension and bus timeout.
module toast_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_alu_result_i,
  input  logic [31:0] ex_rs2_data_i,
  input  logic        ex_mem_rd_i,
  input  logic        ex_mem_wr_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_wr_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stall_q, stall_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_wr_q, wb_reg_wr_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;
  logic [2:0]      cap_f3_q, cap_f3_d;
  logic [1:0]      cap_off_q, cap_off_d;
  logic [4:0]      cap_rd_q, cap_rd_d;
  logic            cap_reg_wr_q, cap_reg_wr_d;

  logic        is_mem, illegal, misal, expire;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, rd_shift, load_val;

  // Request decode: legality, alignment and byte-lane steering of the EX op.
  always_comb begin
    is_mem  = ex_mem_rd_i | ex_mem_wr_i;
    illegal = (ex_mem_rd_i & ex_mem_wr_i)
            | (ex_mem_rd_i & ((ex_funct3_i == 3'd3) | (ex_funct3_i >= 3'd6)))
            | (ex_mem_wr_i & (ex_funct3_i >= 3'd3));
    misal   = ((ex_funct3_i[1:0] == 2'd1) & ex_alu_result_i[0])
            | ((ex_funct3_i[1:0] == 2'd2) & (ex_alu_result_i[1:0] != 2'd0));
    case (ex_funct3_i[1:0])
      2'd0: begin
        be_c    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_c = {4{ex_rs2_data_i[7:0]}};
      end
      2'd1: begin
        be_c    = ex_alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{ex_rs2_data_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_rs2_data_i;
      end
    endcase
    if (!ex_mem_wr_i) wdata_c = 32'd0;
  end

  // Load lane extraction and extension.
  always_comb begin
    rd_shift = dmem_rdata_i >> {cap_off_q, 3'b000};
    case (cap_f3_q)
      3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd4:    load_val = {24'd0, rd_shift[7:0]};
      3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd5:    load_val = {16'd0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_reg_wr_d  = wb_reg_wr_q;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    cap_f3_d     = cap_f3_q;
    cap_off_d    = cap_off_q;
    cap_rd_d     = cap_rd_q;
    cap_reg_wr_d = cap_reg_wr_q;
    expire       = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = ex_alu_result_i;
            wb_rd_d     = ex_rd_addr_i;
            wb_reg_wr_d = ex_reg_wr_i;
          end else if (illegal || misal) begin
            misalign_d  = 1'b1;
            wb_valid_d  = 1'b1;
            wb_data_d   = 32'd0;
            wb_rd_d     = ex_rd_addr_i;
            wb_reg_wr_d = 1'b0;
          end else begin
            state_d      = BUSY;
            cnt_d        = '0;
            req_d        = 1'b1;
            we_d         = ex_mem_wr_i;
            addr_d       = {ex_alu_result_i[31:2], 2'b00};
            be_d         = be_c;
            wdata_d      = wdata_c;
            cap_f3_d     = ex_funct3_i;
            cap_off_d    = ex_alu_result_i[1:0];
            cap_rd_d     = ex_rd_addr_i;
            cap_reg_wr_d = ex_reg_wr_i;
          end
        end
      end
      BUSY: begin
        if (dmem_ack_i || expire) begin
          state_d     = IDLE;
          cnt_d       = '0;
          req_d       = 1'b0;
          we_d        = 1'b0;
          addr_d      = 32'd0;
          be_d        = 4'd0;
          wdata_d     = 32'd0;
          wb_valid_d  = 1'b1;
          wb_rd_d     = cap_rd_q;
          // Ack beats a simultaneous timeout expiry.
          if (dmem_ack_i) begin
            wb_data_d   = we_q ? 32'd0 : load_val;
            wb_reg_wr_d = we_q ? 1'b0 : cap_reg_wr_q;
          end else begin
            bus_err_d   = 1'b1;
            wb_data_d   = 32'd0;
            wb_reg_wr_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d == BUSY);
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      stall_q      <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 32'd0;
      wb_rd_q      <= 5'd0;
      wb_reg_wr_q  <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      cap_f3_q     <= 3'd0;
      cap_off_q    <= 2'd0;
      cap_rd_q     <= 5'd0;
      cap_reg_wr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_reg_wr_q  <= wb_reg_wr_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      cap_f3_q     <= cap_f3_d;
      cap_off_q    <= cap_off_d;
      cap_rd_q     <= cap_rd_d;
      cap_reg_wr_q <= cap_reg_wr_d;
    end
  end

  assign stall_o      = stall_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_data_o    = wb_data_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_reg_wr_o  = wb_reg_wr_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_toast_mem_stage.sv
// Bench for toast_mem_stage: directed and random ops against a byte-level reference model.
module tb_toast_mem_stage;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        ex_valid_i;
  logic [31:0] ex_alu_result_i;
  logic [31:0] ex_rs2_data_i;
  logic        ex_mem_rd_i;
  logic        ex_mem_wr_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_reg_wr_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_reg_wr_o;
  logic        misalign_o;
  logic        bus_err_o;

  int vectors = 0;
  int errs    = 0;

  always #5 clk_i = ~clk_i;

  toast_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .ex_valid_i(ex_valid_i),
    .ex_alu_result_i(ex_alu_result_i), .ex_rs2_data_i(ex_rs2_data_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_wr_i(ex_mem_wr_i), .ex_funct3_i(ex_funct3_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_reg_wr_i(ex_reg_wr_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_reg_wr_o(wb_reg_wr_o), .misalign_o(misalign_o),
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: access size in bytes, legality, lanes and load value.
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_err(input logic [2:0] f3, input logic [31:0] a, input bit ld, input bit st);
    if (ld && st) return 1;
    if (ld && (f3 == 3'd3 || f3 >= 3'd6)) return 1;
    if (st && f3 >= 3'd3) return 1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    longint v;
    int n, off;
    n = nbytes(f3);
    off = int'(a % 4);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(d[8*(off+i) +: 8]) << (8*i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
    return 32'(v);
  endfunction

  task automatic set_ex(input bit v, input logic [31:0] a, input logic [31:0] d, input bit ld,
                        input bit st, input logic [2:0] f3, input logic [4:0] rd, input bit rw);
    ex_valid_i = v; ex_alu_result_i = a; ex_rs2_data_i = d; ex_mem_rd_i = ld;
    ex_mem_wr_i = st; ex_funct3_i = f3; ex_rd_addr_i = rd; ex_reg_wr_i = rw;
  endtask

  task automatic nonmem_op(input logic [31:0] a, input logic [4:0] rd, input bit rw);
    set_ex(1, a, $urandom, 0, 0, 3'($urandom_range(0, 7)), rd, rw);
    tick();
    chk("alu_wb_valid", wb_valid_o, 1);
    chk("alu_wb_data", wb_data_o, a);
    chk("alu_wb_rd", wb_rd_addr_o, rd);
    chk("alu_wb_reg_wr", wb_reg_wr_o, rw);
    chk("alu_no_req", dmem_req_o, 0);
    chk("alu_no_stall", stall_o, 0);
    ex_valid_i = 0;
    tick();
    chk("idle_wb_valid", wb_valid_o, 0);
  endtask

  task automatic err_op(input logic [2:0] f3, input logic [31:0] a, input bit ld, input bit st);
    set_ex(1, a, $urandom, ld, st, f3, 5'd9, 1);
    tick();
    chk("err_misalign", misalign_o, 1);
    chk("err_wb_valid", wb_valid_o, 1);
    chk("err_wb_reg_wr", wb_reg_wr_o, 0);
    chk("err_no_req", dmem_req_o, 0);
    chk("err_no_stall", stall_o, 0);
    chk("err_no_bus_err", bus_err_o, 0);
    ex_valid_i = 0;
    tick();
    chk("err_pulse_end", misalign_o, 0);
    chk("err_no_req2", dmem_req_o, 0);
  endtask

  // One legal access; ack arrives dly cycles after the first request cycle.
  task automatic mem_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d, input bit st,
                        input logic [4:0] rd, input bit rw, input int dly, input logic [31:0] rdata);
    logic [31:0] exp_addr;
    exp_addr = a - (a % 4);
    set_ex(1, a, d, !st, st, f3, rd, rw);
    tick();
    chk("req", dmem_req_o, 1);
    chk("we", dmem_we_o, st);
    chk("addr", dmem_addr_o, exp_addr);
    chk("be", dmem_be_o, model_be(f3, a));
    chk("wdata", dmem_wdata_o, st ? model_wdata(f3, d) : 32'd0);
    chk("stall", stall_o, 1);
    chk("busy_wb_valid", wb_valid_o, 0);
    for (int k = 0; k < dly; k++) begin
      tick();
      chk("req_held", dmem_req_o, 1);
      chk("addr_held", dmem_addr_o, exp_addr);
      chk("be_held", dmem_be_o, model_be(f3, a));
      chk("stall_held", stall_o, 1);
    end
    dmem_ack_i = 1; dmem_rdata_i = rdata;
    tick();
    dmem_ack_i = 0; dmem_rdata_i = $urandom;
    chk("done_wb_valid", wb_valid_o, 1);
    chk("done_wb_data", wb_data_o, st ? 32'd0 : model_load(f3, a, rdata));
    chk("done_wb_reg_wr", wb_reg_wr_o, st ? 1'b0 : rw);
    chk("done_wb_rd", wb_rd_addr_o, rd);
    chk("done_req", dmem_req_o, 0);
    chk("done_stall", stall_o, 0);
    chk("done_bus_err", bus_err_o, 0);
    chk("done_misalign", misalign_o, 0);
    ex_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [2:0] f3;
    logic [31:0] a;
    bit st, ld;

    resetn_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    resetn_i = 1;
    tick();
    chk("post_rst_wb_valid", wb_valid_o, 0);

    nonmem_op(32'h0000_1234, 5'd5, 1);
    mem_op(3'd0, 32'h0000_1003, 0, 0, 5'd7, 1, 2, 32'h80FF_FF7F);
    mem_op(3'd4, 32'h0000_1003, 0, 0, 5'd7, 1, 2, 32'h80FF_FF7F);
    mem_op(3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 1, 5'd3, 1, 1, 0);
    mem_op(3'd1, 32'h0000_3002, 0, 0, 5'd4, 1, 0, 32'h8001_7FFF);
    err_op(3'd2, 32'h0000_2001, 1, 0);
    err_op(3'd3, 32'h0000_2000, 1, 0);
    err_op(3'd0, 32'h0000_2000, 1, 1);

    // Timeout with no ack, then a stray ack in IDLE.
    set_ex(1, 32'h0000_4000, 0, 1, 0, 3'd2, 5'd1, 1);
    tick();
    ex_valid_i = 0;
    cyc = 0;
    while (dmem_req_o === 1'b1 && cyc < 20) begin
      cyc++;
      chk("to_no_bus_err", bus_err_o, 0);
      tick();
    end
    chk("to_req_cycles", 32'(cyc), 4);
    chk("to_bus_err", bus_err_o, 1);
    chk("to_wb_valid", wb_valid_o, 1);
    chk("to_wb_reg_wr", wb_reg_wr_o, 0);
    chk("to_stall", stall_o, 0);
    chk("to_misalign", misalign_o, 0);
    tick();
    chk("to_pulse_end", bus_err_o, 0);
    chk("to_wb_valid_end", wb_valid_o, 0);
    dmem_ack_i = 1;
    tick();
    dmem_ack_i = 0;
    chk("late_ack_wb_valid", wb_valid_o, 0);
    chk("late_ack_req", dmem_req_o, 0);
    chk("late_ack_stall", stall_o, 0);

    // Ack in the final allowed cycle wins over timeout.
    mem_op(3'd2, 32'h0000_5004, 0, 0, 5'd6, 1, 3, 32'h1234_5678);

    // Asynchronous reset during BUSY.
    set_ex(1, 32'h0000_6000, 0, 1, 0, 3'd2, 5'd2, 1);
    tick();
    chk("pre_rst_req", dmem_req_o, 1);
    #2 resetn_i = 0;
    #1;
    chk("mid_rst_req", dmem_req_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_be", dmem_be_o, 0);
    chk("mid_rst_addr", dmem_addr_o, 0);
    chk("mid_rst_wb_valid", wb_valid_o, 0);
    ex_valid_i = 0;
    #1 resetn_i = 1;
    tick();
    chk("post_rst_req", dmem_req_o, 0);
    mem_op(3'd2, 32'h0000_7008, 0, 0, 5'd8, 1, 1, 32'hCAFE_F00D);
    mem_op(3'd2, 32'h0000_700C, 32'h0BAD_C0DE, 1, 5'd8, 1, 0, 0);
    tick();

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: nonmem_op($urandom, 5'($urandom), 1'($urandom));
        1: begin
          st = 1'($urandom);
          if (st) f3 = 3'($urandom_range(0, 2));
          else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
          end
          a = $urandom & ~32'(nbytes(f3) - 1);
          mem_op(f3, a, $urandom, st, 5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
        end
        default: begin
          ld = 1; st = 0; f3 = 0; a = 0;
          for (int t = 0; t < 50; t++) begin
            ld = 1'($urandom); st = ld ? 1'($urandom) : 1'b1;
            f3 = 3'($urandom); a = $urandom;
            if (model_err(f3, a, ld, st)) break;
          end
          if (!model_err(f3, a, ld, st)) begin ld = 1; st = 1; end
          err_op(f3, a, ld, st);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
